seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Parametrised N-digit multiplexed 7-segment display driver. Successor to our single-digit BCD-to-segment decoder.
- Adds a hex mode, a refresh-scan counter, anode multiplexing, decimal points, leading-zero blanking, a selectable output polarity, and tear-free frame-synchronous value loading.
- Sits between datapath result registers and the board's shared segment/anode pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- REFRESH_DIV, 100000: clock cycles each digit is held; legal ≥1; 1 means advance every cycle.
- ACTIVE_LOW, 1: 1 inverts seg, dp and an at the pins; 0 drives them active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- load  in  1  single-cycle request to capture value and dp_in.
- value  in  4*NUM_DIGITS  digit nibbles; [3:0] is digit 0 (rightmost).
- dp_in  in  NUM_DIGITS  decimal-point enables; bit i belongs to digit i.
- hex_en  in  1  1: nibbles 10-15 show A,b,C,d,E,F; 0: nibbles 10-15 are blanked.
- lz_blank  in  1  enables leading-zero blanking.
- load_ack  out  1  one-cycle pulse when a pending load is committed to the display.
- seg  out  7  {g,f,e,d,c,b,a}; bit0 is segment a.
- dp  out  1  decimal-point segment.
- an  out  NUM_DIGITS  digit enables, one-hot; bit i is digit i.

Behaviour:
- Clock and reset: single clock domain, clk. rst is synchronous and active-high and applies on any cycle, including mid-frame.
- Prescaler: counts 0..REFRESH_DIV-1. tick is asserted on the terminal count, after which the prescaler wraps to 0.
- Digit index: advances on tick and wraps from NUM_DIGITS-1 to 0. Width is max(1, $clog2(NUM_DIGITS)).
- Frame boundary: a tick while index==NUM_DIGITS-1.
- Pending register: load captures value and dp_in into the pending register and sets pending_v.
  - A repeat load before commit overwrites the pending data; last load wins and only one ack is issued.
- Commit: at a frame boundary with pending_v=1, pending data is copied to the active register, pending_v clears, and load_ack pulses in the next cycle.
  - If load coincides with a commit, the old pending data commits and the new data becomes pending (pending_v stays 1).
- Displayed data: only the active register is ever displayed, so a frame never mixes old and new digits.
- Decode, active-high pattern hex, bit0=a:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - A=77, b=7C, C=39, d=5E, E=79, F=71.
  - For nibbles 10-15 with hex_en=0, the pattern is 00.
- Leading-zero blanking: when lz_blank=1, digit i>0 shows pattern 00 if it and every higher digit are zero.
  - Digit 0 is never blanked.
  - dp of a blanked digit still follows its dp_in bit.
- Mode inputs: hex_en and lz_blank are sampled live every cycle; they are not latched by load.
- Output timing: seg, dp and an are registered, with 1-cycle latency from the index/active-register state to the pins.
  - Exactly one an bit is active at any time outside reset.
- Polarity: ACTIVE_LOW=1 inverts seg, dp and an after the output register.
- Reset state:
  - Prescaler=0, index=0, active=0, pending_v=0, load_ack=0.
  - seg, dp and an are at their inactive level: all 1 if ACTIVE_LOW, else all 0.
  - The first cycle after reset is released drives digit 0 showing 0 (3F).
  - Reset mid-frame discards both pending and active data.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry SEG7_PATTERNS constant array;
  - SEG_BLANK=7'h00;
  - segment bit-position constants.
- Sub-module seg7_hex_decode: combinational, nibble + hex_en → 7-bit active-high pattern. This generalises the single-digit decoder.
- The top level holds the prescaler, index, pending/active registers, blanking logic and output registers.

Test Plan:
All scenarios use NUM_DIGITS=4 and REFRESH_DIV=4; scenarios 1-5 use ACTIVE_LOW=0.
1. Reset: hold rst 3 cycles → seg=00, dp=0, an=0000. Release → next cycle an=0001, seg=3F. Digit held 4 cycles, then an=0010.
2. Load value=16'h1234, dp_in=4'b0100 mid-frame → no change until the frame boundary, then load_ack pulses once. Next frame shows an=0001/seg=66, 0010/4F, 0100/5B with dp=1, 1000/06.
3. value=16'hABCD with hex_en=1 → digits 0..3 show 5E, 39, 7C, 77. Switch hex_en=0 → all four show 00 on their next slot.
4. lz_blank=1 with value=16'h0070 → digits 3 and 2 show 00, digit 1 shows 07, digit 0 shows 3F. With value=0 → only digit 0 is lit (3F).
5. Two loads (16'h1111 then 16'h2222) in one frame → a single load_ack and 2222 displayed. A load of 16'h3333 on the exact commit cycle → 2222 displays this frame, 3333 commits at the next boundary with a second ack.
6. ACTIVE_LOW=1, display 16'h0008 → digit 0 gives an=1110, seg=00 (~7F), dp=1. Assert rst mid-digit-2 → all outputs 1. After release, digit 0 shows ~3F=40.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display blocks: segment bit positions,
// the blank pattern and the active-high hex glyph table (bit0 = segment a).
package seg7_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [6:0] SEG7_PATTERNS [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef logic [3:0] nibble_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load/mode/display bundle between the datapath (master) and the scan
// driver (slave). Outputs are pin-level, already polarity-adjusted.
interface seg7_scan_driver_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    load;
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic                    hex_en;
   logic                    lz_blank;
   logic                    load_ack;
   logic [6:0]              seg;
   logic                    dp;
   logic [NUM_DIGITS-1:0]   an;

   modport master (
      output load, value, dp_in, hex_en, lz_blank,
      input  load_ack, seg, dp, an
   );

   modport slave (
      input  load, value, dp_in, hex_en, lz_blank,
      output load_ack, seg, dp, an
   );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder; nibbles 10-15 blank unless
// hex_en_i is set. Output is active-high, bit0 = segment a.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  nibble_t    nibble_i,
   input  logic       hex_en_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG7_PATTERNS[nibble_i];
      if (!hex_en_i && (nibble_i > 4'd9)) begin
         seg_o = SEG_BLANK;
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed 7-segment driver: refresh prescaler, digit scan,
// frame-synchronous pending->active commit, leading-zero blanking, pin polarity.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   seg7_scan_driver_if.slave  bus
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int VAL_W = 4 * NUM_DIGITS;

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [VAL_W-1:0]      act_val_q, act_val_d, pend_val_q, pend_val_d;
   logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
   logic                  pend_v_q, pend_v_d;
   logic                  ack_q, ack_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;

   logic       tick, frame_end, commit;
   nibble_t    nib;
   logic       blank;
   logic [6:0] dec_seg;

   assign tick      = (cnt_q == CNT_W'(REFRESH_DIV - 1));
   assign frame_end = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
   assign commit    = frame_end && pend_v_q;

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (tick) begin
         idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
      if (bus.load) begin
         pend_val_d = bus.value;
         pend_dp_d  = bus.dp_in;
      end
      // A load on the commit cycle re-arms pending with the new data
      pend_v_d  = bus.load | (pend_v_q & ~commit);
      act_val_d = commit ? pend_val_q : act_val_q;
      act_dp_d  = commit ? pend_dp_q  : act_dp_q;
      ack_d     = commit;
   end

   // Digit select, one-hot anode and leading-zero run from the top digit down
   always_comb begin
      logic zero_above;
      nib        = '0;
      dp_d       = 1'b0;
      an_d       = '0;
      blank      = 1'b0;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above && (act_val_q[4*i +: 4] == 4'd0);
         if (idx_q == IDX_W'(i)) begin
            nib     = act_val_q[4*i +: 4];
            dp_d    = act_dp_q[i];
            an_d[i] = 1'b1;
            blank   = bus.lz_blank && (i != 0) && zero_above;
         end
      end
   end

   seg7_hex_decode u_dec (
      .nibble_i (nib),
      .hex_en_i (bus.hex_en),
      .seg_o    (dec_seg)
   );

   assign seg_d = blank ? SEG_BLANK : dec_seg;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         act_val_q <= '0;
         act_dp_q  <= '0;
         pend_v_q  <= 1'b0;
         ack_q     <= 1'b0;
         seg_q     <= '0;
         dp_q      <= 1'b0;
         an_q      <= '0;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         act_val_q <= act_val_d;
         act_dp_q  <= act_dp_d;
         pend_v_q  <= pend_v_d;
         ack_q     <= ack_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         an_q      <= an_d;
      end
   end

   // Pending data is qualified by pend_v_q, so it needs no reset
   always_ff @(posedge clk) begin
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
   end

   assign bus.load_ack = ack_q;
   assign bus.seg      = seg_q ^ {7{ACTIVE_LOW}};
   assign bus.dp       = dp_q ^ ACTIVE_LOW;
   assign bus.an       = an_q ^ {NUM_DIGITS{ACTIVE_LOW}};

endmodule
